// File: rtl/project_switcher_pkg.sv
// Shared definitions for the project switcher.
//   SEL_BITS_DEF / NUM_PROJ_DEF : default select width and project count
//   state_t                     : sequencer state encoding (BOOT=0, IDLE=1, ASSERT=2, SETTLE=3)
//   max_int                     : helper used to size the shared down-counter
package project_switcher_pkg;

    localparam int SEL_BITS_DEF = 2;
    localparam int NUM_PROJ_DEF = 4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ASSERT = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/project_switcher_if.sv
// Request/mux bus of the project switcher.
//   req_valid/req_sel/req_ready : switch-request handshake
//   ext_rst_n                   : user/pad reset into the sequencer, active-low
//   sel/mux_rst_n               : select and reset driven to the project mux
//   busy/done/err               : status (busy = ~req_ready, done/err one-cycle pulses)
// master = requester side, slave = the switcher.
interface project_switcher_if
    import project_switcher_pkg::*;
#(
    parameter int SEL_BITS = SEL_BITS_DEF
);
    logic                req_valid;
    logic [SEL_BITS-1:0] req_sel;
    logic                req_ready;
    logic                ext_rst_n;
    logic [SEL_BITS-1:0] sel;
    logic                mux_rst_n;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_sel, ext_rst_n,
        input  req_ready, sel, mux_rst_n, busy, done, err
    );

    modport slave (
        input  req_valid, req_sel, ext_rst_n,
        output req_ready, sel, mux_rst_n, busy, done, err
    );
endinterface

// File: rtl/project_switcher_sw_timer.sv
// sw_timer: loadable down-counter that stops at zero.
//   clk, rst  : clock, asynchronous active-high reset (counter resets to RST_VAL)
//   load      : load load_val this edge (takes priority over counting)
//   load_val  : value to load
//   zero      : counter currently at zero
module sw_timer
    import project_switcher_pkg::*;
#(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/project_switcher.sv
// project_switcher: sequences project changes on the project input mux.
// A switch holds the mux in reset, changes sel, waits for the mux's registered
// clock-gate select to settle, then releases reset on the new project, so sel
// never moves while the selected project runs.
//   clk, rst : clock shared with the mux, asynchronous active-high reset
//   bus      : project_switcher_if.slave (request handshake, ext_rst_n, sel,
//              mux_rst_n, busy, done, err)
module project_switcher
    import project_switcher_pkg::*;
#(
    parameter int SEL_BITS      = SEL_BITS_DEF,
    parameter int NUM_PROJ      = NUM_PROJ_DEF,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    project_switcher_if.slave bus
);
    localparam int CNT_W = $clog2(max_int(RST_CYCLES, SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [SEL_BITS-1:0] tgt_q, tgt_d;
    logic                force_rst_q, force_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                timer_load;
    logic [CNT_W-1:0]    timer_val;
    logic                timer_zero;
    logic                req_ready;
    logic                req_in_range;

    // The timer resets to RST_LOAD so the boot hold needs no extra load state.
    sw_timer #(
        .W       (CNT_W),
        .RST_VAL (RST_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign req_ready    = (state_q == ST_IDLE);
    assign req_in_range = (int'(bus.req_sel) < NUM_PROJ);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        tgt_d       = tgt_q;
        force_rst_d = force_rst_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        timer_load  = 1'b0;
        timer_val   = RST_LOAD;
        case (state_q)
            ST_BOOT: begin
                if (timer_zero) begin
                    force_rst_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (!req_in_range) begin
                        err_d = 1'b1;
                    end else begin
                        // Same-project requests are restarts: run the full window.
                        tgt_d       = bus.req_sel;
                        force_rst_d = 1'b1;
                        timer_load  = 1'b1;
                        timer_val   = RST_LOAD;
                        state_d     = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (timer_zero) begin
                    sel_d      = tgt_q;
                    timer_load = 1'b1;
                    timer_val  = SETTLE_LOAD;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    force_rst_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            sel_q       <= '0;
            tgt_q       <= '0;
            force_rst_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tgt_q       <= tgt_d;
            force_rst_q <= force_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // The pad reset bypasses the FSM so it reaches the mux in the same cycle.
    assign bus.mux_rst_n = bus.ext_rst_n & ~force_rst_q;
    assign bus.req_ready = req_ready;
    assign bus.busy      = ~req_ready;
    assign bus.sel       = sel_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_project_switcher.sv
// Self-checking bench for project_switcher. Instance A uses the defaults
// (NUM_PROJ=4); instance B uses NUM_PROJ=3 for the out-of-range request.
// Stimulus pushes expected done/err events into per-instance queues; monitors
// pop and compare them whenever the DUT pulses done or err.
module tb_project_switcher;
    import project_switcher_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    project_switcher_if #(.SEL_BITS(2)) a_if ();
    project_switcher_if #(.SEL_BITS(2)) b_if ();

    project_switcher #(.SEL_BITS(2), .NUM_PROJ(4), .RST_CYCLES(4), .SETTLE_CYCLES(2))
        dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    project_switcher #(.SEL_BITS(2), .NUM_PROJ(3), .RST_CYCLES(4), .SETTLE_CYCLES(2))
        dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] sel;
        int         cyc;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    ev_t ea, eb;
    logic [1:0] sel_prev_a = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.done || a_if.err) begin
                if (q_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL A unexpected event: done=%0b err=%0b, want none (cyc %0d)", a_if.done, a_if.err, cyc);
                end else begin
                    ea = q_a.pop_front();
                    chk("A err", a_if.err, ea.is_err);
                    chk("A done", a_if.done, !ea.is_err);
                    chk("A event sel", a_if.sel, ea.sel);
                    chk("A event cycle", cyc, ea.cyc);
                    $display("txn A %s sel=%0d cyc=%0d", ea.is_err ? "err" : "done", a_if.sel, cyc);
                end
            end
            if (a_if.sel != sel_prev_a)
                chk("A sel moved while out of reset", a_if.mux_rst_n, 0);
            if (b_if.done || b_if.err) begin
                if (q_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL B unexpected event: done=%0b err=%0b, want none (cyc %0d)", b_if.done, b_if.err, cyc);
                end else begin
                    eb = q_b.pop_front();
                    chk("B err", b_if.err, eb.is_err);
                    chk("B done", b_if.done, !eb.is_err);
                    chk("B event sel", b_if.sel, eb.sel);
                    chk("B event cycle", cyc, eb.cyc);
                    $display("txn B %s sel=%0d cyc=%0d", eb.is_err ? "err" : "done", b_if.sel, cyc);
                end
            end
        end
        sel_prev_a = a_if.sel;
    end

    // Releases rst (called at posedge+1 with rst high) and checks the boot hold.
    task automatic boot_check();
        rst = 1'b0;
        chk("boot mux_rst_n at release", a_if.mux_rst_n, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("boot A mux_rst_n edge %0d", k), a_if.mux_rst_n, (k == 4) ? 1 : 0);
            chk($sformatf("boot B mux_rst_n edge %0d", k), b_if.mux_rst_n, (k == 4) ? 1 : 0);
        end
        chk("boot sel", a_if.sel, 0);
        chk("boot req_ready", a_if.req_ready, 1);
        chk("boot busy", a_if.busy, 0);
        $display("txn boot complete cyc=%0d", cyc);
    endtask

    task automatic req_a(input logic [1:0] s, output int e0);
        int w;
        w = 0;
        a_if.req_valid = 1'b1;
        a_if.req_sel   = s;
        while (!a_if.req_ready && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) chk("A req_ready timeout", 0, 1);
        tick();
        e0 = cyc;
        a_if.req_valid = 1'b0;
        $display("txn A request sel=%0d accepted cyc=%0d", s, e0);
    endtask

    initial begin
        int e0, e1;
        a_if.req_valid = 1'b0; a_if.req_sel = '0; a_if.ext_rst_n = 1'b1;
        b_if.req_valid = 1'b0; b_if.req_sel = '0; b_if.ext_rst_n = 1'b1;

        // 1. reset state and boot
        repeat (3) tick();
        chk("reset sel", a_if.sel, 0);
        chk("reset mux_rst_n", a_if.mux_rst_n, 0);
        chk("reset req_ready", a_if.req_ready, 0);
        chk("reset done", a_if.done, 0);
        chk("reset err", a_if.err, 0);
        boot_check();
        tick();

        // 2. switch 0 -> 2
        req_a(2'd2, e0);
        q_a.push_back('{is_err: 1'b0, sel: 2'd2, cyc: e0 + 6});
        for (int k = 0; k <= 6; k++) begin
            chk($sformatf("switch mux_rst_n +%0d", k), a_if.mux_rst_n, (k < 6) ? 0 : 1);
            chk($sformatf("switch sel +%0d", k), a_if.sel, (k < 4) ? 0 : 2);
            if (k < 6) tick();
        end
        chk("switch req_ready after done", a_if.req_ready, 1);
        tick();

        // 3. back-pressure: valid held, req_sel toggling during the switch
        a_if.req_valid = 1'b1;
        a_if.req_sel   = 2'd1;
        tick();
        e0 = cyc;
        $display("txn A request sel=1 accepted cyc=%0d", e0);
        q_a.push_back('{is_err: 1'b0, sel: 2'd1, cyc: e0 + 6});
        for (int k = 0; k <= 6; k++) begin
            a_if.req_sel = (k % 2 == 0) ? 2'd3 : 2'd0;
            chk($sformatf("bp req_ready +%0d", k), a_if.req_ready, (k == 6) ? 1 : 0);
            tick();
        end
        e1 = cyc;
        a_if.req_valid = 1'b0;
        $display("txn A request sel=3 accepted cyc=%0d", e1);
        q_a.push_back('{is_err: 1'b0, sel: 2'd3, cyc: e1 + 6});
        chk("bp second accept busy", a_if.busy, 1);
        repeat (6) tick();
        chk("bp final sel", a_if.sel, 3);
        chk("bp final req_ready", a_if.req_ready, 1);
        tick();

        // 4. out-of-range on the NUM_PROJ=3 instance, then its top legal value
        b_if.req_valid = 1'b1;
        b_if.req_sel   = 2'd3;
        tick();
        e0 = cyc;
        b_if.req_valid = 1'b0;
        $display("txn B request sel=3 accepted cyc=%0d", e0);
        q_b.push_back('{is_err: 1'b1, sel: 2'd0, cyc: e0});
        chk("oor busy", b_if.busy, 0);
        chk("oor mux_rst_n", b_if.mux_rst_n, 1);
        chk("oor sel", b_if.sel, 0);
        tick();
        chk("oor err single cycle", b_if.err, 0);
        chk("oor busy later", b_if.busy, 0);
        b_if.req_valid = 1'b1;
        b_if.req_sel   = 2'd2;
        tick();
        e0 = cyc;
        b_if.req_valid = 1'b0;
        $display("txn B request sel=2 accepted cyc=%0d", e0);
        q_b.push_back('{is_err: 1'b0, sel: 2'd2, cyc: e0 + 6});
        chk("B legal busy", b_if.busy, 1);
        repeat (6) tick();
        chk("B legal sel", b_if.sel, 2);
        chk("B legal ready", b_if.req_ready, 1);
        tick();

        // 5. restart of the running project, then pad reset in IDLE
        req_a(2'd3, e0);
        q_a.push_back('{is_err: 1'b0, sel: 2'd3, cyc: e0 + 6});
        for (int k = 0; k <= 6; k++) begin
            chk($sformatf("restart mux_rst_n +%0d", k), a_if.mux_rst_n, (k < 6) ? 0 : 1);
            chk($sformatf("restart sel +%0d", k), a_if.sel, 3);
            if (k < 6) tick();
        end
        tick();
        a_if.ext_rst_n = 1'b0;
        #1;
        chk("pad reset mux_rst_n", a_if.mux_rst_n, 0);
        chk("pad reset req_ready", a_if.req_ready, 1);
        a_if.ext_rst_n = 1'b1;
        #1;
        chk("pad release mux_rst_n", a_if.mux_rst_n, 1);
        $display("txn A pad reset pulse cyc=%0d", cyc);
        tick();

        // 6. rst two cycles into ASSERT
        req_a(2'd3, e0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        $display("txn A rst mid-switch cyc=%0d", cyc);
        chk("midrst sel", a_if.sel, 0);
        chk("midrst mux_rst_n", a_if.mux_rst_n, 0);
        chk("midrst req_ready", a_if.req_ready, 0);
        tick();
        tick();
        boot_check();
        repeat (10) tick();
        chk("midrst target discarded sel", a_if.sel, 0);
        chk("midrst idle", a_if.req_ready, 1);

        repeat (3) tick();
        chk("A pending events", q_a.size(), 0);
        chk("B pending events", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
